// File: rtl/mem_port_arbiter_if.sv
// Bundle between mem_port_arbiter, its two requesters and mem_controller.
// slave: the arbiter's view. master: the environment driving requests and memory responses.
interface mem_port_arbiter_if #(
  parameter int ADDR_BITS = 14,
  parameter int DATA_BITS = 32
);
  localparam int BE_BITS = DATA_BITS / 8;

  logic [ADDR_BITS-1:0] req0_addr;
  logic                 req0_read_en;
  logic [BE_BITS-1:0]   req0_write_en;
  logic [DATA_BITS-1:0] req0_write_data;
  logic [DATA_BITS-1:0] req0_read_data;
  logic                 req0_read_ack;
  logic                 req0_write_ack;

  logic [ADDR_BITS-1:0] req1_addr;
  logic                 req1_read_en;
  logic [BE_BITS-1:0]   req1_write_en;
  logic [DATA_BITS-1:0] req1_write_data;
  logic [DATA_BITS-1:0] req1_read_data;
  logic                 req1_read_ack;
  logic                 req1_write_ack;

  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_read_en;
  logic [BE_BITS-1:0]   mem_write_en;
  logic [DATA_BITS-1:0] mem_write_data;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_read_ack;
  logic                 mem_write_ack;

  logic [1:0]           grant;
  logic                 timeout_err;

  modport slave (
    input  req0_addr, req0_read_en, req0_write_en, req0_write_data,
    output req0_read_data, req0_read_ack, req0_write_ack,
    input  req1_addr, req1_read_en, req1_write_en, req1_write_data,
    output req1_read_data, req1_read_ack, req1_write_ack,
    output mem_addr, mem_read_en, mem_write_en, mem_write_data,
    input  mem_read_data, mem_read_ack, mem_write_ack,
    output grant, timeout_err
  );

  modport master (
    output req0_addr, req0_read_en, req0_write_en, req0_write_data,
    input  req0_read_data, req0_read_ack, req0_write_ack,
    output req1_addr, req1_read_en, req1_write_en, req1_write_data,
    input  req1_read_data, req1_read_ack, req1_write_ack,
    input  mem_addr, mem_read_en, mem_write_en, mem_write_data,
    output mem_read_data, mem_read_ack, mem_write_ack,
    input  grant, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the mem_controller port between the core (port 0)
// and the debugger/loader (port 1). One single-cycle command per transaction,
// acks routed back to the owner, watchdog forces completion if memory stays silent.
module mem_port_arbiter #(
  parameter int ADDR_BITS      = 14,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_reset,
  mem_port_arbiter_if.slave bus
);
  localparam int         BE_BITS   = DATA_BITS / 8;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [7:0] WDOG_INIT = 8'(TIMEOUT_CYCLES);

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [BE_BITS-1:0]   be_q, be_d;
  logic [7:0]           wdog_q, wdog_d;

  // Requests gathered into port-indexed arrays so the grant can select by owner.
  logic [1:0][ADDR_BITS-1:0] req_addr;
  logic [1:0][DATA_BITS-1:0] req_wdata;
  logic [1:0][BE_BITS-1:0]   req_be;
  logic [1:0]                req_rd, pend;
  logic                      gnt;

  assign req_addr  = {bus.req1_addr, bus.req0_addr};
  assign req_wdata = {bus.req1_write_data, bus.req0_write_data};
  assign req_be    = {bus.req1_write_en, bus.req0_write_en};
  assign req_rd    = {bus.req1_read_en, bus.req0_read_en};
  assign pend      = req_rd | {|req_be[1], |req_be[0]};
  // Tie goes to the port that did not own the last transaction.
  assign gnt       = (&pend) ? ~last_q : ~pend[0];

  // sync_reset suppresses every pulse in the cycle it is asserted.
  logic run, issue, waiting, acked, tmo, done;
  assign run     = ~sync_reset;
  assign issue   = run & (state_q == S_ISSUE);
  assign waiting = run & (state_q == S_WAIT);
  assign acked   = waiting & (bus.mem_read_ack | bus.mem_write_ack);
  assign tmo     = waiting & ~acked & (wdog_q == 8'd1);
  assign done    = acked | tmo;

  // Next-state: grant from IDLE, single-cycle ISSUE, WAIT until ack or watchdog.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wdog_d  = wdog_q;
    if (sync_reset) begin
      state_d = S_IDLE;
      owner_d = 1'b0;
      last_d  = 1'b1;
      wr_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      be_d    = '0;
      wdog_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (|pend) begin
          owner_d = gnt;
          addr_d  = req_addr[gnt];
          wdata_d = req_wdata[gnt];
          be_d    = req_be[gnt];
          wr_d    = |req_be[gnt];
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          wdog_d  = WDOG_INIT;
          state_d = S_WAIT;
        end
        S_WAIT: if (done) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          wdog_d  = wdog_q - 8'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; last_q resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wdog_q  <= wdog_d;
    end
  end

  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_read_en    = issue & ~wr_q;
  assign bus.mem_write_en   = issue ? be_q : '0;
  assign bus.grant          = (run && state_q != S_IDLE) ? {1'b1, owner_q} : 2'b00;
  assign bus.timeout_err    = tmo;

  // Per-port completion routing; the non-owner always sees zeros.
  logic [1:0]                rack, wack;
  logic [1:0][DATA_BITS-1:0] rdata;
  for (genvar i = 0; i < 2; i++) begin : g_port
    logic mine;
    assign mine     = (i == 0) ? ~owner_q : owner_q;
    assign rack[i]  = done & mine & ~wr_q;
    assign wack[i]  = done & mine & wr_q;
    assign rdata[i] = (acked & mine & ~wr_q) ? bus.mem_read_data : '0;
  end

  assign bus.req0_read_ack  = rack[0];
  assign bus.req0_write_ack = wack[0];
  assign bus.req0_read_data = rdata[0];
  assign bus.req1_read_ack  = rack[1];
  assign bus.req1_write_ack = wack[1];
  assign bus.req1_read_data = rdata[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checking every
// cycle, a table of single transactions, hand sequences, and random traffic.
module tb_mem_port_arbiter;
  localparam int AB  = 14;
  localparam int DB  = 32;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync_reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks one outstanding transaction by its age in cycles since the grant edge:
  // age 1 is the command cycle, acks count from age 2, watchdog fires at age TMO+1.
  bit          m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_wr = 1'b0;
  int          m_age = 0;
  logic [3:0]  m_be = '0;
  logic [13:0] m_addr = '0;
  logic [31:0] m_wdata = '0;

  always @(negedge clk) begin : mon
    bit en, cmd, acked, tmo, done, p0, p1;
    if (!reset_n) begin
      m_busy = 1'b0; m_last = 1'b1; m_addr = '0; m_wdata = '0;
    end
    en    = reset_n && !sync_reset;
    cmd   = en && m_busy && m_age == 1;
    acked = en && m_busy && m_age >= 2 && (bus.mem_read_ack || bus.mem_write_ack);
    tmo   = en && m_busy && !acked && m_age == TMO + 1;
    done  = acked || tmo;
    chk("mem_read_en", bus.mem_read_en, cmd && !m_wr);
    chk("mem_write_en", bus.mem_write_en, cmd ? m_be : 4'b0);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_write_data", bus.mem_write_data, m_wdata);
    chk("grant", bus.grant, (en && m_busy) ? {1'b1, m_owner} : 2'b00);
    chk("timeout_err", bus.timeout_err, tmo);
    chk("req0_read_ack", bus.req0_read_ack, done && !m_owner && !m_wr);
    chk("req0_write_ack", bus.req0_write_ack, done && !m_owner && m_wr);
    chk("req0_read_data", bus.req0_read_data, (acked && !m_owner && !m_wr) ? bus.mem_read_data : 32'h0);
    chk("req1_read_ack", bus.req1_read_ack, done && m_owner && !m_wr);
    chk("req1_write_ack", bus.req1_write_ack, done && m_owner && m_wr);
    chk("req1_read_data", bus.req1_read_data, (acked && m_owner && !m_wr) ? bus.mem_read_data : 32'h0);
    // advance to the next cycle
    if (!en) begin
      m_busy = 1'b0; m_last = 1'b1; m_addr = '0; m_wdata = '0;
    end else if (!m_busy) begin
      p0 = bus.req0_read_en || (bus.req0_write_en != 4'b0);
      p1 = bus.req1_read_en || (bus.req1_write_en != 4'b0);
      if (p0 || p1) begin
        m_owner = (p0 && p1) ? !m_last : p1;
        m_busy  = 1'b1;
        m_age   = 1;
        if (!m_owner) begin
          m_be = bus.req0_write_en; m_addr = bus.req0_addr; m_wdata = bus.req0_write_data;
        end else begin
          m_be = bus.req1_write_en; m_addr = bus.req1_addr; m_wdata = bus.req1_write_data;
        end
        m_wr = (m_be != 4'b0);
      end
    end else if (done) begin
      m_busy = 1'b0; m_last = m_owner;
    end else begin
      m_age++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit p, input bit rd, input logic [3:0] be,
                         input logic [13:0] a, input logic [31:0] d);
    if (!p) begin
      bus.req0_read_en = rd; bus.req0_write_en = be; bus.req0_addr = a; bus.req0_write_data = d;
    end else begin
      bus.req1_read_en = rd; bus.req1_write_en = be; bus.req1_addr = a; bus.req1_write_data = d;
    end
  endtask

  task automatic clr_mem();
    bus.mem_read_ack = 1'b0; bus.mem_write_ack = 1'b0; bus.mem_read_data = '0;
  endtask

  typedef struct {
    bit          port;
    bit          rd;
    logic [3:0]  be;
    logic [13:0] addr;
    logic [31:0] wdata;
    int          ack_dly;   // cycles after the command cycle; 0 = memory never answers
    bit          ack_wr;    // answer with mem_write_ack instead of mem_read_ack
    logic [31:0] rdata;
    bit          exp_mrd;
    logic [3:0]  exp_mbe;
    bit          exp_rack;
    bit          exp_wack;
    logic [31:0] exp_rdata;
    bit          exp_tmo;
  } vec_t;

  vec_t vecs[6];

  // One transaction on an idle arbiter; checks command, hold, latency and ack routing.
  task automatic run_vec(input int idx, input vec_t v);
    int k_done, exp_k;
    bit got_r, got_w, got_t, oth;
    logic [31:0] got_d;
    k_done = 0; got_r = 0; got_w = 0; got_t = 0; oth = 0; got_d = '0;
    set_req(v.port, v.rd, v.be, v.addr, v.wdata);
    @(negedge clk);
    chk($sformatf("v%0d_idle_grant", idx), bus.grant, 2'b00);
    tick();
    @(negedge clk);
    chk($sformatf("v%0d_cmd_read_en", idx), bus.mem_read_en, v.exp_mrd);
    chk($sformatf("v%0d_cmd_write_en", idx), bus.mem_write_en, v.exp_mbe);
    chk($sformatf("v%0d_cmd_addr", idx), bus.mem_addr, v.addr);
    chk($sformatf("v%0d_cmd_grant", idx), bus.grant, {1'b1, v.port});
    for (int k = 1; k <= 40 && k_done == 0; k++) begin
      tick();
      bus.mem_read_ack  = (k == v.ack_dly) && !v.ack_wr;
      bus.mem_write_ack = (k == v.ack_dly) && v.ack_wr;
      bus.mem_read_data = (k == v.ack_dly) ? v.rdata : 32'h5A5A_A5A5;
      @(negedge clk);
      chk($sformatf("v%0d_hold_wdata", idx), bus.mem_write_data, v.wdata);
      chk($sformatf("v%0d_hold_enables", idx), {bus.mem_read_en, bus.mem_write_en}, 5'b0);
      if (bus.req0_read_ack || bus.req0_write_ack || bus.req1_read_ack ||
          bus.req1_write_ack || bus.timeout_err) begin
        k_done = k;
        got_r = v.port ? bus.req1_read_ack  : bus.req0_read_ack;
        got_w = v.port ? bus.req1_write_ack : bus.req0_write_ack;
        got_d = v.port ? bus.req1_read_data : bus.req0_read_data;
        oth   = v.port ? (bus.req0_read_ack | bus.req0_write_ack) : (bus.req1_read_ack | bus.req1_write_ack);
        got_t = bus.timeout_err;
      end
    end
    exp_k = (v.ack_dly != 0) ? v.ack_dly : TMO;
    chk($sformatf("v%0d_latency", idx), k_done, exp_k);
    chk($sformatf("v%0d_read_ack", idx), got_r, v.exp_rack);
    chk($sformatf("v%0d_write_ack", idx), got_w, v.exp_wack);
    chk($sformatf("v%0d_read_data", idx), got_d, v.exp_rdata);
    chk($sformatf("v%0d_timeout", idx), got_t, v.exp_tmo);
    chk($sformatf("v%0d_other_ack", idx), oth, 1'b0);
    tick();
    clr_mem();
    set_req(v.port, 1'b0, 4'b0, '0, '0);
    @(negedge clk);
    chk($sformatf("v%0d_back_idle", idx), bus.grant, 2'b00);
    tick();
  endtask

  // ---------------- random traffic state ----------------
  bit act[2];
  bit fin[2];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n, cd, seen;
    bit prev_busy;
    bit owners[4];

    set_req(1'b0, 1'b0, 4'b0, '0, '0);
    set_req(1'b1, 1'b0, 4'b0, '0, '0);
    clr_mem();

    //           port  rd    be    addr      wdata         dly wr    rdata         mrd   mbe   rack  wack  rdata_exp     tmo
    vecs[0] = '{1'b0, 1'b1, 4'h0, 14'h0010, 32'h0000_0000, 2, 1'b0, 32'h1234_5678, 1'b1, 4'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'h6, 14'h02A5, 32'hAABB_CCDD, 3, 1'b1, 32'h1111_1111, 1'b0, 4'h6, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'hF, 14'h3FFF, 32'hDEAD_BEEF, 1, 1'b1, 32'h2222_2222, 1'b0, 4'hF, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'h0, 14'h1ABC, 32'h0000_0000, 1, 1'b1, 32'hCAFE_F00D, 1'b1, 4'h0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'h0, 14'h0555, 32'h0000_0000, 0, 1'b0, 32'h7777_7777, 1'b1, 4'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 4'h1, 14'h0001, 32'h0000_00A5, 5, 1'b0, 32'h9999_9999, 1'b0, 4'h1, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

    // async reset held for two edges; the monitor checks the reset outputs
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // late mem ack after a watchdog expiry must be ignored
    set_req(1'b0, 1'b1, 4'b0, 14'h0123, '0);
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.timeout_err) seen = 1;
      else tick();
    end
    chk("late_timeout_seen", seen, 1);
    tick();
    set_req(1'b0, 1'b0, 4'b0, '0, '0);
    tick();
    tick();
    bus.mem_read_ack = 1'b1; bus.mem_read_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_ack_no_rack", bus.req0_read_ack, 1'b0);
    chk("late_ack_no_rdata", bus.req0_read_data, 32'h0);
    chk("late_ack_no_tmo", bus.timeout_err, 1'b0);
    tick();
    clr_mem();
    tick();

    // both ports read continuously after a reset: grants alternate 0,1,0,1
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    set_req(1'b0, 1'b1, 4'b0, 14'h0100, '0);
    set_req(1'b1, 1'b1, 4'b0, 14'h0200, '0);
    n = 0; cd = -1; prev_busy = 1'b0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (bus.mem_read_en) begin
        owners[n] = bus.grant[0];
        chk("alt_idle_gap", prev_busy, 1'b0);
        n++;
        cd = 2;
      end
      prev_busy = bus.grant[1];
      tick();
      if (cd >= 0) cd--;
      bus.mem_read_ack  = (cd == 0);
      bus.mem_read_data = $urandom;
    end
    chk("alt_count", n, 4);
    chk("alt_owners", {owners[0], owners[1], owners[2], owners[3]}, 4'b0101);
    set_req(1'b0, 1'b0, 4'b0, '0, '0);
    set_req(1'b1, 1'b0, 4'b0, '0, '0);
    // let any outstanding transaction finish (ack or watchdog) before moving on
    repeat (4) tick();
    clr_mem();
    repeat (TMO + 2) tick();

    // sync_reset in WAIT abandons the transaction, then a tie goes to port 0
    set_req(1'b1, 1'b1, 4'b0, 14'h0042, '0);
    tick();
    tick();
    sync_reset = 1'b1; bus.mem_read_ack = 1'b1; bus.mem_read_data = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("srst_no_ack", bus.req1_read_ack, 1'b0);
    tick();
    sync_reset = 1'b0;
    set_req(1'b0, 1'b1, 4'b0, 14'h0043, '0);
    @(negedge clk);
    chk("srst_grant_cleared", bus.grant, 2'b00);
    chk("srst_late_ack_ignored", {bus.req0_read_ack, bus.req1_read_ack}, 2'b00);
    tick();
    clr_mem();
    @(negedge clk);
    chk("srst_tie_port0", bus.grant, 2'b10);
    tick();
    bus.mem_read_ack = 1'b1; bus.mem_read_data = 32'h600D_F00D;
    @(negedge clk);
    chk("srst_port0_ack", bus.req0_read_ack, 1'b1);
    chk("srst_port0_data", bus.req0_read_data, 32'h600D_F00D);
    tick();
    clr_mem();
    set_req(1'b0, 1'b0, 4'b0, '0, '0);
    set_req(1'b1, 1'b0, 4'b0, '0, '0);
    repeat (TMO + 4) tick();

    // random traffic, checked by the monitor every cycle
    act[0] = 1'b0; act[1] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 2) == 0) begin
          int t;
          act[p] = 1'b1;
          t = $urandom_range(0, 3);
          case (t)
            0, 3:    set_req(p[0], 1'b1, 4'b0, 14'($urandom), $urandom);
            1:       set_req(p[0], 1'b0, 4'($urandom_range(1, 15)), 14'($urandom), $urandom);
            default: set_req(p[0], 1'b1, 4'($urandom_range(1, 15)), 14'($urandom), $urandom);
          endcase
        end
      end
      begin
        int r;
        r = $urandom_range(0, 7);
        bus.mem_read_ack  = (r == 0) || (r == 2);
        bus.mem_write_ack = (r == 1) || (r == 2);
        bus.mem_read_data = $urandom;
      end
      sync_reset = ($urandom_range(0, 199) == 0);
      if (i == 1500) reset_n = 1'b0;
      if (i == 1502) reset_n = 1'b1;
      @(negedge clk);
      fin[0] = bus.req0_read_ack | bus.req0_write_ack;
      fin[1] = bus.req1_read_ack | bus.req1_write_ack;
      tick();
      for (int p = 0; p < 2; p++) begin
        if (fin[p]) begin
          act[p] = 1'b0;
          set_req(p[0], 1'b0, 4'b0, '0, '0);
        end
      end
    end
    sync_reset = 1'b0;
    clr_mem();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
